// File: rtl/div_radix4_if.sv
// Control/result bundle between the calculator control block and the divider.
interface div_radix4_if;
  logic        op_start;
  logic        op_clear;
  logic        signed_op;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  modport master (
    output op_start, op_clear, signed_op, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  op_start, op_clear, signed_op, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/div_radix4.sv
// Sequential 64-bit restoring divider, two quotient bits per cycle, 32 cycles.
module div_radix4 (
  input  logic        clk,
  input  logic        reset,
  div_radix4_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt;
  // Partial remainder is always < divisor, so its 65th bit is only needed
  // transiently inside a step and is not stored.
  logic [63:0] prem;
  logic [63:0] qacc;   // dividend bits shift out, quotient bits shift in
  logic [63:0] dvs;
  logic        q_neg, r_neg;

  logic        dvs_zero, launch, sd, sv;
  logic [63:0] dvd_mag, dvs_mag;
  logic [127:0] s1, s2;
  logic [63:0] q_fix, r_fix;

  // One restoring step: shift in the next dividend bit, trial subtract.
  function automatic logic [127:0] rstep(input logic [63:0] r, input logic [63:0] q,
                                         input logic [63:0] d);
    logic [64:0] sh, tr;
    sh = {r, q[63]};
    tr = sh - {1'b0, d};
    if (!tr[64]) rstep = {tr[63:0], q[62:0], 1'b1};
    else         rstep = {sh[63:0], q[62:0], 1'b0};
  endfunction

  // Operand conditioning and the two chained steps of one cycle.
  always_comb begin
    dvs_zero = (bus.divisor == 64'd0);
    launch   = bus.op_start && !bus.op_clear && (state != EXEC);
    sd       = bus.signed_op && bus.dividend[63];
    sv       = bus.signed_op && bus.divisor[63];
    dvd_mag  = sd ? (64'd0 - bus.dividend) : bus.dividend;
    dvs_mag  = sv ? (64'd0 - bus.divisor)  : bus.divisor;
    s1       = rstep(prem, qacc, dvs);
    s2       = rstep(s1[127:64], s1[63:0], dvs);
    q_fix    = q_neg ? (64'd0 - s2[63:0])   : s2[63:0];
    r_fix    = r_neg ? (64'd0 - s2[127:64]) : s2[127:64];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; clear beats start, start is ignored while iterating.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (bus.op_clear)      state_nx = IDLE;
        else if (bus.op_start) state_nx = dvs_zero ? DONE : EXEC;
      end
      EXEC: begin
        if (bus.op_clear)        state_nx = IDLE;
        else if (cnt == 5'd31)   state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    bus.busy = (state == EXEC);
    bus.done = (state == DONE);
  end

  // Datapath and registered results.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt             <= 5'd0;
      prem            <= 64'd0;
      qacc            <= 64'd0;
      dvs             <= 64'd0;
      q_neg           <= 1'b0;
      r_neg           <= 1'b0;
      bus.quotient    <= 64'd0;
      bus.remainder   <= 64'd0;
      bus.div_by_zero <= 1'b0;
    end else if (bus.op_clear) begin
      cnt             <= 5'd0;
      bus.quotient    <= 64'd0;
      bus.remainder   <= 64'd0;
      bus.div_by_zero <= 1'b0;
    end else if (launch) begin
      cnt             <= 5'd0;
      prem            <= 64'd0;
      qacc            <= dvd_mag;
      dvs             <= dvs_mag;
      q_neg           <= sd ^ sv;
      r_neg           <= sd;
      bus.div_by_zero <= dvs_zero;
      // Divide by zero completes immediately with the raw dividend.
      if (dvs_zero) begin
        bus.quotient  <= '1;
        bus.remainder <= bus.dividend;
      end
    end else if (state == EXEC) begin
      prem <= s2[127:64];
      qacc <= s2[63:0];
      cnt  <= cnt + 5'd1;
      if (cnt == 5'd31) begin
        bus.quotient  <= q_fix;
        bus.remainder <= r_fix;
      end
    end
  end

endmodule

// File: tb/tb_div_radix4.sv
// Directed bench for div_radix4: latency, signs, div-by-zero, abort, reset.
module tb_div_radix4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  div_radix4_if bus ();

  div_radix4 dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch at the next edge t; returns at the negedge following t.
  task automatic start(input logic s, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    bus.signed_op = s;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.op_start  = 1'b1;
    @(negedge clk);
    bus.op_start  = 1'b0;
  endtask

  // Full operation with busy/done timing checked every cycle up to t+32.
  task automatic run_div(input string tag, input logic s, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] eq, input logic [63:0] er);
    start(s, a, b);
    for (int i = 0; i < 32; i++) begin
      chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
      chk({tag, "_done_early"}, 64'(bus.done), 64'd0);
      @(negedge clk);
    end
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
    chk({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
    chk({tag, "_dbz"}, 64'(bus.div_by_zero), 64'd0);
    chk({tag, "_q"}, bus.quotient, eq);
    chk({tag, "_r"}, bus.remainder, er);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_q"}, bus.quotient, 64'd0);
    chk({tag, "_r"}, bus.remainder, 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_dbz"}, 64'(bus.div_by_zero), 64'd0);
  endtask

  initial begin
    bus.op_start  = 1'b0;
    bus.op_clear  = 1'b0;
    bus.signed_op = 1'b0;
    bus.dividend  = 64'd0;
    bus.divisor   = 64'd0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    // Basic unsigned and signed cases
    run_div("u100_7", 1'b0, 64'd100, 64'd7, 64'd14, 64'd2);
    run_div("s-100_7", 1'b1, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE);
    run_div("s100_-7", 1'b1, 64'd100, -64'sd7, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2);
    run_div("s-7_2", 1'b1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF);

    // Divide by zero completes one edge after start
    start(1'b0, 64'd5, 64'd0);
    chk("dz_done", 64'(bus.done), 64'd1);
    chk("dz_flag", 64'(bus.div_by_zero), 64'd1);
    chk("dz_busy", 64'(bus.busy), 64'd0);
    chk("dz_q", bus.quotient, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("dz_r", bus.remainder, 64'd5);

    // Extremes (first launched from DONE of div-by-zero: flag must drop)
    run_div("s_ovf", 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0000, 64'd0);
    run_div("u_max_1", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    run_div("u_3_max", 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd3);

    // Clear from DONE zeroes the results
    @(negedge clk);
    bus.op_clear = 1'b1;
    @(negedge clk);
    bus.op_clear = 1'b0;
    chk_zero("clr_done");

    // Clear and start together: clear wins
    @(negedge clk);
    bus.dividend = 64'd9; bus.divisor = 64'd3; bus.signed_op = 1'b0;
    bus.op_clear = 1'b1; bus.op_start = 1'b1;
    @(negedge clk);
    bus.op_clear = 1'b0; bus.op_start = 1'b0;
    chk("both_busy", 64'(bus.busy), 64'd0);
    chk("both_done", 64'(bus.done), 64'd0);

    // Abort: start ignored mid-run, clear aborts, done never asserts
    start(1'b0, 64'd1000, 64'd3);
    repeat (4) @(negedge clk);
    bus.dividend = 64'd50; bus.divisor = 64'd0; bus.op_start = 1'b1;
    @(negedge clk);
    bus.op_start = 1'b0;
    chk("ign_busy", 64'(bus.busy), 64'd1);
    chk("ign_dbz", 64'(bus.div_by_zero), 64'd0);
    repeat (4) @(negedge clk);
    bus.op_clear = 1'b1;
    @(negedge clk);
    bus.op_clear = 1'b0;
    chk_zero("abort");
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("abort_no_done", 64'(bus.done), 64'd0);
    end
    run_div("u1000_3", 1'b0, 64'd1000, 64'd3, 64'd333, 64'd1);

    // Reset mid-operation
    start(1'b0, 64'd12345, 64'd10);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_zero("rst_mid");
    reset = 1'b0;

    // Back-to-back, second launched from DONE
    run_div("b2b_1", 1'b0, 64'd1000000, 64'd1000, 64'd1000, 64'd0);
    run_div("b2b_2", 1'b0, 64'd77, 64'd5, 64'd15, 64'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/div_radix4.md
# div_radix4

Sequential 64-bit integer divider producing two quotient bits per clock, 32 iteration cycles per operation. It is the divide counterpart of the radix-4 multiply datapath in the calculator: the control block drives it with a start/clear handshake and reads quotient and remainder when `done` is high. Signed and unsigned operands are supported. Signed results truncate toward zero.

## Interface
- No parameters; operand width fixed at 64.
- `clk`  in  1  Sole clock; all state updates on rising edge.
- `reset`  in  1  Synchronous, active-high reset.
- `op_start`  in  1  Launch a division with the current operands.
- `op_clear`  in  1  Abort or clear; return to IDLE.
- `signed_op`  in  1  1 = two's-complement operands, 0 = unsigned; sampled with `op_start`.
- `dividend`  in  64  Dividend; sampled with `op_start`.
- `divisor`  in  64  Divisor; sampled with `op_start`.
- `quotient`  out  64  Registered quotient.
- `remainder`  out  64  Registered remainder.
- `busy`  out  1  High while iterating.
- `done`  out  1  High while results are valid.
- `div_by_zero`  out  1  High with `done` when the sampled divisor was 0.

## Operation
- **Reset.** `reset` has priority over every other input. Its effect:
  - state = IDLE, iteration counter = 0;
  - `quotient`, `remainder`, `busy`, `done`, `div_by_zero` = 0.
- **States.** IDLE, EXEC, DONE.
- **IDLE + `op_start`.**
  - Latch the magnitudes of `dividend` and `divisor`. When `signed_op`=1, negate negative operands; otherwise take them as-is.
  - Latch quotient sign = sign(dividend) XOR sign(divisor) and remainder sign = sign(dividend). Both are 0 when unsigned.
  - Clear the partial remainder (65 bits). Go to EXEC; `busy`=1.
  - If `divisor`==0, go to DONE instead:
    - `quotient`=64'hFFFF_FFFF_FFFF_FFFF;
    - `remainder`=`dividend` (raw, not sign-processed);
    - `div_by_zero`=1.
- **EXEC, each cycle.** Perform two restoring steps, MSB-first:
  - shift {partial remainder, dividend} left 1;
  - trial-subtract the divisor magnitude;
  - if the result is non-negative, keep it and shift in quotient bit 1, else restore and shift in 0.
  - The second step operates on the first step's result within the same cycle.
- **EXEC, after 32 cycles** (counter 31 → wrap):
  - apply sign fix: negate the quotient if its sign is 1, negate the remainder if its sign is 1;
  - register `quotient`/`remainder`; `busy`=0, `done`=1; go to DONE.
- **DONE.**
  - Outputs hold, with `done`=1.
  - `op_start` launches a new operation exactly as from IDLE; `done` and `div_by_zero` drop to 0 on that edge.
  - `op_clear` goes to IDLE and zeroes `quotient`, `remainder`, `done`, `div_by_zero`.
- **Signed overflow.** 64'h8000_0000_0000_0000 / 64'hFFFF_FFFF_FFFF_FFFF gives `quotient`=64'h8000_0000_0000_0000 and `remainder`=0. This is the natural result of magnitude division plus negation; no flag is raised.
- **Invariants.** For every non-zero divisor: dividend = quotient·divisor + remainder, and |remainder| < |divisor|.

## Timing
- **Start.** `op_start` sampled at edge t (IDLE or DONE) → `busy`=1 from t.
- **Result.** Final result registered at edge t+32: `done`=1 and `busy`=0 visible after t+32.
- **Latency.** 32 cycles, fixed, independent of operand values.
- **Divide by zero.** `done`=1 and `div_by_zero`=1 after edge t; no EXEC cycles.
- **Start while busy.** `op_start` during EXEC is ignored; operands are not re-sampled.
- **Clear while busy.** `op_clear` during EXEC aborts: IDLE at the next edge, `busy`=0, outputs zeroed.
- **Simultaneous inputs.** `op_clear` and `op_start` together: `op_clear` wins.
- **Reset mid-operation.** Reset at any edge returns to the reset values on that edge. The partial result is discarded.
- **Output stability.** Outputs change only at the edges listed above. `quotient`/`remainder` are stable while `done`=1.

## Test plan
- **Unsigned.** 100 / 7, `signed_op`=0, start at t → at t+32: `done`=1, `quotient`=14, `remainder`=2, `busy`=0; `busy`=1 for cycles t..t+31.
- **Signed.** -100 / 7, `signed_op`=1 → `quotient`=64'hFFFF_FFFF_FFFF_FFF2 (-14), `remainder`=64'hFFFF_FFFF_FFFF_FFFE (-2). Also check 100 / -7 → -14, 2.
- **Divide by zero.** 5 / 0 → one cycle after start: `done`=1, `div_by_zero`=1, `quotient`=all ones, `remainder`=5.
- **Extremes.** Signed 64'h8000_0000_0000_0000 / -1 → `quotient`=64'h8000_0000_0000_0000, `remainder`=0. Unsigned all-ones / 1 → all ones, 0. Unsigned 3 / 64'hFFFF_FFFF_FFFF_FFFF → 0, 3.
- **Abort and ignore.** Start 1000/3; pulse `op_start` with new operands at t+5 → ignored. Pulse `op_clear` at t+10 → IDLE at t+11, `busy`=0, `done` never asserts. Restart → correct 333 r 1 at 32 cycles.
- **Reset and back-to-back.** Assert `reset` at t+20 of an operation → all outputs 0 next cycle. Then run two divisions back-to-back, the second started from DONE → each `done` exactly 32 cycles after its start.
